// File: rtl/interlock_sequencer.sv
// Airlock interlock sequencer.
// Walks a chamber between EVACUATED and PRESSURIZED through timed transfer
// states, granting door unlock permission only in the settled states.
// Optional feature macro: INTERLOCK_ABORT_EN -- when defined, a door sensor
// dropping during a transfer aborts into FAULT, which is left only by
// fault_clear with both doors closed.
module interlock_sequencer #(
  parameter int PRESS_TICKS = 5,
  parameter int EVAC_TICKS  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       pressurize_req,
  input  logic       evacuate_req,
  input  logic       outer_closed,
  input  logic       inner_closed,
  input  logic       fault_clear,
  output logic       outer_door_en,
  output logic       inner_door_en,
  output logic       pump_on,
  output logic       vent_on,
  output logic       busy,
  output logic       fault,
  output logic [3:0] remaining
);

  typedef enum logic [2:0] {
    EVACUATED    = 3'd0,
    PRESSURIZING = 3'd1,
    PRESSURIZED  = 3'd2,
    EVACUATING   = 3'd3,
    FAULT        = 3'd4
  } state_t;

  localparam logic [3:0] PRESS_LOAD = 4'(PRESS_TICKS);
  localparam logic [3:0] EVAC_LOAD  = 4'(EVAC_TICKS);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] count;
  logic [3:0] count_nxt;
  logic       doors_closed;

  assign doors_closed = outer_closed & inner_closed;

`ifndef INTERLOCK_ABORT_EN
  // Without the abort feature the acknowledge input has no purpose.
  logic unused_fault_clear;
  assign unused_fault_clear = fault_clear;
`endif

  // State and transfer counter registers; reset lands in EVACUATED at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= EVACUATED;
      count <= 4'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state/counter logic: accept requests only when settled with both
  // doors shut; a tick at count 1 finishes the transfer and clears the count.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      EVACUATED: begin
        if (pressurize_req && doors_closed) begin
          state_nxt = PRESSURIZING;
          count_nxt = PRESS_LOAD;
        end
      end
      PRESSURIZED: begin
        if (evacuate_req && doors_closed) begin
          state_nxt = EVACUATING;
          count_nxt = EVAC_LOAD;
        end
      end
      PRESSURIZING, EVACUATING: begin
`ifdef INTERLOCK_ABORT_EN
        if (!doors_closed) begin
          state_nxt = FAULT;
          count_nxt = 4'd0;
        end else
`endif
        if (tick) begin
          if (count <= 4'd1) begin
            state_nxt = (state == PRESSURIZING) ? PRESSURIZED : EVACUATED;
            count_nxt = 4'd0;
          end else begin
            count_nxt = count - 4'd1;
          end
        end
      end
      FAULT: begin
`ifdef INTERLOCK_ABORT_EN
        if (fault_clear && doors_closed) begin
          state_nxt = EVACUATED;
          count_nxt = 4'd0;
        end
`else
        // Unreachable in this build; recover to the safe state.
        state_nxt = EVACUATED;
        count_nxt = 4'd0;
`endif
      end
      default: begin
        state_nxt = EVACUATED;
        count_nxt = 4'd0;
      end
    endcase
  end

  // Output decode from the state register only, so door and drive pairs
  // can never be asserted together.
  always_comb begin
    outer_door_en = 1'b0;
    inner_door_en = 1'b0;
    pump_on       = 1'b0;
    vent_on       = 1'b0;
    busy          = 1'b0;
    fault         = 1'b0;
    case (state)
      EVACUATED:    outer_door_en = 1'b1;
      PRESSURIZED:  inner_door_en = 1'b1;
      PRESSURIZING: begin
        pump_on = 1'b1;
        busy    = 1'b1;
      end
      EVACUATING: begin
        vent_on = 1'b1;
        busy    = 1'b1;
      end
      FAULT:        fault = 1'b1;
      default:      outer_door_en = 1'b0;
    endcase
  end

  assign remaining = count;

endmodule

// File: tb/tb_interlock_sequencer.sv
// Self-checking bench for interlock_sequencer: directed scenarios plus a
// randomized run checked against a behavioural chamber model.
module tb_interlock_sequencer;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       pressurize_req;
  logic       evacuate_req;
  logic       outer_closed;
  logic       inner_closed;
  logic       fault_clear;
  logic       outer_door_en;
  logic       inner_door_en;
  logic       pump_on;
  logic       vent_on;
  logic       busy;
  logic       fault;
  logic [3:0] remaining;

  int unsigned total = 0;
  int unsigned bad   = 0;

`ifdef INTERLOCK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  // Observed outputs: {outer, inner, pump, vent, busy, fault, remaining}
  logic [9:0] obs;
  assign obs = {outer_door_en, inner_door_en, pump_on, vent_on, busy, fault, remaining};

  interlock_sequencer #(.PRESS_TICKS(5), .EVAC_TICKS(8)) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .pressurize_req(pressurize_req), .evacuate_req(evacuate_req),
    .outer_closed(outer_closed), .inner_closed(inner_closed),
    .fault_clear(fault_clear),
    .outer_door_en(outer_door_en), .inner_door_en(inner_door_en),
    .pump_on(pump_on), .vent_on(vent_on), .busy(busy), .fault(fault),
    .remaining(remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural chamber model: where the air is, and how many ticks remain.
  typedef enum int {AT_VACUUM, FILLING, AT_PRESSURE, EMPTYING, FAULTED} chamber_t;
  chamber_t m_mode = AT_VACUUM;
  int       m_left = 0;

  function automatic logic [9:0] exp_vec();
    logic [3:0] r;
    r = 4'(m_left);
    case (m_mode)
      AT_VACUUM:   return {6'b100000, r};
      AT_PRESSURE: return {6'b010000, r};
      FILLING:     return {6'b001010, r};
      EMPTYING:    return {6'b000110, r};
      default:     return {6'b000001, r};
    endcase
  endfunction

  function automatic void model_reset();
    m_mode = AT_VACUUM;
    m_left = 0;
  endfunction

  // One clock edge of the chamber rules, using the inputs present at the edge.
  function automatic void model_step();
    bit shut;
    shut = outer_closed && inner_closed;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_mode == FILLING || m_mode == EMPTYING) begin
      if (ABORT && !shut) begin
        m_mode = FAULTED;
        m_left = 0;
      end else if (tick) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = (m_mode == FILLING) ? AT_PRESSURE : AT_VACUUM;
      end
    end else if (m_mode == AT_VACUUM && pressurize_req && shut) begin
      m_mode = FILLING;
      m_left = 5;
    end else if (m_mode == AT_PRESSURE && evacuate_req && shut) begin
      m_mode = EMPTYING;
      m_left = 8;
    end else if (m_mode == FAULTED && fault_clear && shut) begin
      m_mode = AT_VACUUM;
    end
  endfunction

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  // n clocks; tick asserted only at the last edge when t_last is set.
  task automatic run(input int n, input bit t_last);
    for (int i = 0; i < n; i++) begin
      tick = t_last && (i == n - 1);
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick = 0; pressurize_req = 0; evacuate_req = 0; fault_clear = 0;
    outer_closed = 1; inner_closed = 1;
    #1;
    model_reset();
    cyc(); cyc();
    total++;
    if (obs !== 10'b1000000000) begin
      bad++; $display("FAIL reset_state obs=%b exp=%b", obs, 10'b1000000000);
    end
    reset = 1'b0;
    cyc();
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL reset_release obs=%b exp=%b", obs, exp_vec());
    end
  endtask

  task automatic test_pressurize();
    pressurize_req = 1;
    cyc();
    pressurize_req = 0;
    total++;
    if (obs !== {6'b001010, 4'd5}) begin
      bad++; $display("FAIL press_accept obs=%b exp=%b", obs, {6'b001010, 4'd5});
    end
    for (int k = 1; k <= 5; k++) begin
      run(70, 1'b1);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL press_tick%0d obs=%b exp=%b", k, obs, exp_vec());
      end
    end
    total++;
    if (obs !== {6'b010000, 4'd0}) begin
      bad++; $display("FAIL press_done obs=%b exp=%b", obs, {6'b010000, 4'd0});
    end
  endtask

  task automatic test_evacuate();
    evacuate_req = 1;
    cyc();
    evacuate_req = 0;
    total++;
    if (obs !== {6'b000110, 4'd8}) begin
      bad++; $display("FAIL evac_accept obs=%b exp=%b", obs, {6'b000110, 4'd8});
    end
    for (int k = 1; k <= 7; k++) run(70, 1'b1);
    run(69, 1'b0);
    total++;
    if (obs !== {6'b000110, 4'd1}) begin
      bad++; $display("FAIL evac_clk559 obs=%b exp=%b", obs, {6'b000110, 4'd1});
    end
    run(1, 1'b1);
    total++;
    if (obs !== {6'b100000, 4'd0}) begin
      bad++; $display("FAIL evac_clk560 obs=%b exp=%b", obs, {6'b100000, 4'd0});
    end
  endtask

  task automatic test_ignored();
    outer_closed = 0;
    pressurize_req = 1;
    run(3, 1'b1);
    total++;
    if (obs !== 10'b1000000000) begin
      bad++; $display("FAIL ign_outer_open obs=%b exp=%b", obs, 10'b1000000000);
    end
    outer_closed = 1; inner_closed = 0;
    cyc();
    total++;
    if (obs !== 10'b1000000000) begin
      bad++; $display("FAIL ign_inner_open obs=%b exp=%b", obs, 10'b1000000000);
    end
    inner_closed = 1; pressurize_req = 0; evacuate_req = 1;
    run(3, 1'b1);
    evacuate_req = 0;
    total++;
    if (obs !== 10'b1000000000) begin
      bad++; $display("FAIL ign_evac_in_vac obs=%b exp=%b", obs, 10'b1000000000);
    end
  endtask

  task automatic test_tick_coincident();
    tick = 1; pressurize_req = 1;
    cyc();
    tick = 0; pressurize_req = 0;
    total++;
    if (obs !== {6'b001010, 4'd5}) begin
      bad++; $display("FAIL tick_on_accept obs=%b exp=%b", obs, {6'b001010, 4'd5});
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    pressurize_req = 1;
    cyc();
    pressurize_req = 0;
    run(70, 1'b1);
    run(70, 1'b1);
    total++;
    if (obs !== {6'b001010, 4'd3}) begin
      bad++; $display("FAIL pre_reset_rem3 obs=%b exp=%b", obs, {6'b001010, 4'd3});
    end
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (obs !== 10'b1000000000) begin
      bad++; $display("FAIL async_reset obs=%b exp=%b", obs, 10'b1000000000);
    end
    cyc();
    reset = 1'b0;
    pressurize_req = 1;
    cyc();
    pressurize_req = 0;
    total++;
    if (obs !== {6'b001010, 4'd5}) begin
      bad++; $display("FAIL resume_after_reset obs=%b exp=%b", obs, {6'b001010, 4'd5});
    end
    do_reset();
  endtask

  task automatic test_door_during_transfer();
    pressurize_req = 1;
    cyc();
    pressurize_req = 0;
    for (int k = 0; k < 5; k++) run(1, 1'b1);
    evacuate_req = 1;
    cyc();
    evacuate_req = 0;
    inner_closed = 0;
    cyc();
`ifdef INTERLOCK_ABORT_EN
    total++;
    if (obs !== {6'b000001, 4'd0}) begin
      bad++; $display("FAIL abort_fault obs=%b exp=%b", obs, {6'b000001, 4'd0});
    end
    fault_clear = 1;
    cyc();
    total++;
    if (obs !== {6'b000001, 4'd0}) begin
      bad++; $display("FAIL clear_door_open obs=%b exp=%b", obs, {6'b000001, 4'd0});
    end
    inner_closed = 1;
    cyc();
    fault_clear = 0;
    total++;
    if (obs !== 10'b1000000000) begin
      bad++; $display("FAIL clear_to_vac obs=%b exp=%b", obs, 10'b1000000000);
    end
`else
    total++;
    if (obs !== {6'b000110, 4'd8}) begin
      bad++; $display("FAIL door_ignored obs=%b exp=%b", obs, {6'b000110, 4'd8});
    end
    fault_clear = 1;
    run(1, 1'b1);
    fault_clear = 0;
    inner_closed = 1;
    total++;
    if (obs !== {6'b000110, 4'd7}) begin
      bad++; $display("FAIL door_ignored_tick obs=%b exp=%b", obs, {6'b000110, 4'd7});
    end
    do_reset();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      tick           = ($urandom_range(0, 3) == 0);
      pressurize_req = ($urandom_range(0, 2) == 0);
      evacuate_req   = ($urandom_range(0, 2) == 0);
      outer_closed   = ($urandom_range(0, 15) != 0);
      inner_closed   = ($urandom_range(0, 15) != 0);
      fault_clear    = ($urandom_range(0, 4) == 0);
      cyc();
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL random_cyc%0d obs=%b exp=%b", i, obs, exp_vec());
      end
      if ((outer_door_en && inner_door_en) || (pump_on && vent_on)) begin
        bad++; $display("FAIL exclusion_cyc%0d obs=%b exp=no_overlap", i, obs);
      end
    end
    tick = 0; pressurize_req = 0; evacuate_req = 0; fault_clear = 0;
    outer_closed = 1; inner_closed = 1;
  endtask

  initial begin
    test_reset();
    test_pressurize();
    test_evacuate();
    test_ignored();
    test_tick_coincident();
    test_reset_mid();
    test_door_during_transfer();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
